kalman_matmul_sched: RTL and testbench

KALMAN_MATMUL_SCHED -- requirements
Module: kalman_matmul_sched

---
 rtl/kalman_matmul_sched.sv | 117 +++++++++++
 tb/tb_kalman_matmul_sched.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/kalman_matmul_sched.sv
// Two-requester round-robin scheduler around one PxP fixed-point matrix multiplier.
// Each RUN cycle computes one element of C (P MACs), so a job occupies P*P RUN cycles.
module kalman_matmul_sched #(
  parameter int N = 32,
  parameter int Q = 18,
  parameter int P = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [P*P*N-1:0] a0,
  input  logic [P*P*N-1:0] b0,
  input  logic [P*P*N-1:0] a1,
  input  logic [P*P*N-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [P*P*N-1:0] c,
  output logic             overflow,
  output logic             busy
);
  localparam int E  = P * P;
  localparam int IW = (E > 1) ? $clog2(E) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [IW-1:0]    idx_q;
  logic [E*N-1:0]   opa_q, opb_q, buf_q, buf_d;
  logic             ovf_q, last_q, owner_q;
  logic             win1, elem_ovf;
  logic [N-1:0]     ea, eb;
  logic [2*N-1:0]   prod;
  logic signed [2*N-1:0] sh;
  logic [N+1:0]     acc;
  int               r, col;

  // Requester 1 wins only when alone or when requester 0 was served last.
  assign win1 = req1 & (~req0 | ~last_q);
  assign busy = (state_q != IDLE);

  always_comb begin
    r        = int'(idx_q) / P;
    col      = int'(idx_q) % P;
    acc      = '0;
    elem_ovf = 1'b0;
    ea       = '0;
    eb       = '0;
    prod     = '0;
    sh       = '0;
    for (int k = 0; k < P; k++) begin
      ea   = opa_q[(r*P+k)*N +: N];
      eb   = opb_q[(k*P+col)*N +: N];
      prod = {{N{ea[N-1]}}, ea} * {{N{eb[N-1]}}, eb};
      sh   = $signed(prod) >>> Q;
      if (sh[2*N-1:N-1] != {(N+1){sh[N-1]}}) elem_ovf = 1'b1;
      acc  = acc + {{2{sh[N-1]}}, sh[N-1:0]};
      if (acc[N+1:N-1] != {3{acc[N-1]}}) elem_ovf = 1'b1;
    end
    buf_d = buf_q;
    buf_d[int'(idx_q)*N +: N] = acc[N-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      buf_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      ovf_q    <= 1'b0;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      c        <= '0;
      overflow <= 1'b0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state_q)
        IDLE: if (req0 || req1) begin
          state_q <= RUN;
          idx_q   <= '0;
          ovf_q   <= 1'b0;
          owner_q <= win1;
          last_q  <= win1;
          gnt0    <= ~win1;
          gnt1    <= win1;
          opa_q   <= win1 ? a1 : a0;
          opb_q   <= win1 ? b1 : b0;
        end
        RUN: begin
          buf_q <= buf_d;
          ovf_q <= ovf_q | elem_ovf;
          idx_q <= idx_q + IW'(1);
          // The last element bypasses the buffer so C is ready on DONE entry.
          if (idx_q == IW'(E-1)) begin
            state_q  <= DONE;
            c        <= buf_d;
            overflow <= ovf_q | elem_ovf;
            done0    <= ~owner_q;
            done1    <= owner_q;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_kalman_matmul_sched.sv
// Randomized bench for kalman_matmul_sched against an arithmetic matrix-product model.
module tb_kalman_matmul_sched;
  localparam int N = 32, Q = 18, P = 4, E = P * P;
  localparam int SPACING = E + 2;

  logic             clk = 1'b0, reset = 1'b1, req0 = 1'b0, req1 = 1'b0;
  logic [E*N-1:0]   a0 = '0, b0 = '0, a1 = '0, b1 = '0, c;
  logic             gnt0, gnt1, done0, done1, overflow, busy;

  int n_chk = 0, n_err = 0, cyc = 0;
  int last_w = 1;
  int g_cyc = 0;

  kalman_matmul_sched #(.N(N), .Q(Q), .P(P)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .c(c), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [E*N-1:0] obs, input logic [E*N-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // C = A*B with each product shifted by Q and narrowed to N bits, sums wrapped to N bits.
  function automatic void mm_ref(input logic [E*N-1:0] a, input logic [E*N-1:0] b,
                                 output logic [E*N-1:0] cc, output logic ov);
    longint pr, s;
    int tr;
    cc = '0;
    ov = 1'b0;
    for (int r = 0; r < P; r++)
      for (int col = 0; col < P; col++) begin
        s = 0;
        for (int k = 0; k < P; k++) begin
          pr = longint'($signed(a[(r*P+k)*N +: N])) * longint'($signed(b[(k*P+col)*N +: N]));
          pr = pr >>> Q;
          if (pr > 64'sd2147483647 || pr < -64'sd2147483648) ov = 1'b1;
          tr = int'(pr);
          s  = s + longint'(tr);
          if (s > 64'sd2147483647 || s < -64'sd2147483648) ov = 1'b1;
        end
        cc[(r*P+col)*N +: N] = s[31:0];
      end
  endfunction

  function automatic logic [E*N-1:0] rnd_mat(input bit big);
    logic [E*N-1:0] m;
    for (int i = 0; i < E; i++)
      m[i*N +: N] = big ? $urandom : ($urandom_range(0, 2**21) - 2**20);
    return m;
  endfunction

  task automatic scramble();
    a0 = rnd_mat($urandom_range(0, 3) == 0);
    b0 = rnd_mat(1'b0);
    a1 = rnd_mat($urandom_range(0, 3) == 0);
    b1 = rnd_mat(1'b0);
  endtask

  // Waits for a grant, checks winner, latency, result and idle return.
  task automatic run_job(input string tag, input bit drop);
    int n, bad, w;
    logic [E*N-1:0] ec;
    logic eo;
    w = (req0 && req1) ? (last_w == 1 ? 0 : 1) : (req1 ? 1 : 0);
    n = 0;
    do begin tick(); n++; end while (!(gnt0 || gnt1) && n < 60);
    chk({tag, "_gnt"}, E*N'(gnt0 | gnt1), E*N'(1));
    chk({tag, "_who"}, E*N'({gnt1, gnt0}), E*N'(w ? 2'b10 : 2'b01));
    last_w = w;
    g_cyc  = cyc;
    mm_ref(w ? a1 : a0, w ? b1 : b0, ec, eo);
    if (drop) begin req0 = 1'b0; req1 = 1'b0; end
    scramble();
    n = 0; bad = 0;
    do begin
      tick(); n++;
      if (gnt0 || gnt1 || !busy) bad++;
    end while (!(done0 || done1) && n < 40);
    chk({tag, "_lat"}, E*N'(n), E*N'(E));
    chk({tag, "_done"}, E*N'({done1, done0}), E*N'(w ? 2'b10 : 2'b01));
    chk({tag, "_c"}, c, ec);
    chk({tag, "_ovf"}, E*N'(overflow), E*N'(eo));
    chk({tag, "_busy"}, E*N'(bad), '0);
    tick();
    chk({tag, "_idle"}, E*N'({busy, gnt0, gnt1, done0, done1}), '0);
  endtask

  initial begin
    logic [E*N-1:0] exp_m;
    int g_prev, n, bad;

    tick(); tick();
    chk("rst_c", c, '0);
    chk("rst_flags", E*N'({gnt0, gnt1, done0, done1, overflow, busy}), '0);
    reset = 1'b0;

    // Contention right after reset: 0,1,0,1 at fixed spacing.
    scramble();
    req0 = 1'b1; req1 = 1'b1;
    run_job("cont0", 1'b0);
    g_prev = g_cyc;
    for (int j = 1; j < 4; j++) begin
      run_job($sformatf("cont%0d", j), j == 3);
      chk("cont_space", E*N'(g_cyc - g_prev), E*N'(SPACING));
      g_prev = g_cyc;
    end

    // Identity times a ramp gives the ramp back.
    a0 = '0; b0 = '0;
    for (int r = 0; r < P; r++) begin
      a0[(r*P+r)*N +: N] = 32'h0004_0000;
      for (int k = 0; k < P; k++) b0[(r*P+k)*N +: N] = (r*4+k) << 18;
    end
    exp_m = b0;
    req0 = 1'b1;
    run_job("ident", 1'b1);
    chk("ident_ramp", c, exp_m);

    // 2.0*I times all-1.5.
    a1 = '0;
    for (int r = 0; r < P; r++) a1[(r*P+r)*N +: N] = 32'h0008_0000;
    for (int i = 0; i < E; i++) begin
      b1[i*N +: N] = 32'h0006_0000;
      exp_m[i*N +: N] = 32'h000C_0000;
    end
    req1 = 1'b1;
    run_job("scale", 1'b1);
    chk("scale_c", c, exp_m);

    // Product overflow, then a clean job clears the flag.
    a0 = '0; b0 = '0;
    a0[N-1:0] = 32'h1000_0000;
    b0[N-1:0] = 32'h1000_0000;
    req0 = 1'b1;
    run_job("ovf", 1'b1);
    chk("ovf_set", E*N'(overflow), E*N'(1));
    a0 = rnd_mat(1'b0); b0 = rnd_mat(1'b0);
    req0 = 1'b1;
    run_job("clean", 1'b1);
    chk("ovf_clr", E*N'(overflow), '0);

    // Held req0 re-grants every job slot.
    req0 = 1'b1;
    run_job("held0", 1'b0);
    g_prev = g_cyc;
    for (int j = 1; j < 3; j++) begin
      run_job("held", j == 2);
      chk("held_space", E*N'(g_cyc - g_prev), E*N'(SPACING));
      g_prev = g_cyc;
    end

    // Random mix of requesters and operand ranges.
    for (int j = 0; j < 8; j++) begin
      n = $urandom_range(1, 3);
      req0 = n[0]; req1 = n[1];
      run_job($sformatf("rnd%0d", j), j == 7);
    end

    // Reset during RUN at idx 7 aborts the job.
    req0 = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!gnt0 && n < 60);
    chk("abort_gnt", E*N'(gnt0), E*N'(1));
    req0 = 1'b0;
    repeat (7) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    last_w = 1;
    chk("abort_c", c, '0);
    chk("abort_flags", E*N'({busy, overflow, done0, done1}), '0);
    bad = 0;
    repeat (20) begin tick(); if (done0 || done1 || busy) bad++; end
    chk("abort_nodone", E*N'(bad), '0);
    req0 = 1'b1; req1 = 1'b1;
    run_job("post", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
